// File: rtl/fifo_uart_tx.sv
// Read-side FIFO client: drains bytes and serialises each one as a UART 8N1 frame.
// Pops are combinational so the FIFO front is captured in the same cycle as the pop.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 1250,
  parameter int WIDTH        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_enable,
  input  logic             i_fifo_empty,
  input  logic [WIDTH-1:0] i_fifo_data,
  output logic             o_fifo_pop,
  output logic             o_tx,
  output logic             o_busy
);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t            r_state, w_state_nxt;
  logic [BAUD_W-1:0] r_baud, w_baud_nxt;
  logic [BIT_W-1:0]  r_bit, w_bit_nxt;
  logic [WIDTH-1:0]  r_shift, w_shift_nxt;
  logic              r_empty_q, r_tx, r_busy;
  logic              w_tx_nxt, w_busy_nxt, w_bit_end, w_pop;

  assign w_bit_end = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));
  // empty_q blocks a pop in the first cycle after the FIFO was empty
  assign w_pop = !rst && (r_state == S_IDLE) && i_enable && !i_fifo_empty && !r_empty_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_empty_q <= 1'b1;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_baud    <= w_baud_nxt;
      r_bit     <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
      r_empty_q <= i_fifo_empty;
      r_tx      <= w_tx_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    case (r_state)
      S_IDLE: begin
        if (w_pop) begin
          w_state_nxt = S_START;
          w_baud_nxt  = '0;
          w_shift_nxt = i_fifo_data;
        end
      end
      S_START: begin
        w_baud_nxt = w_bit_end ? '0 : r_baud + 1'b1;
        if (w_bit_end) begin
          w_state_nxt = S_DATA;
          w_bit_nxt   = '0;
        end
      end
      S_DATA: begin
        w_baud_nxt = w_bit_end ? '0 : r_baud + 1'b1;
        if (w_bit_end) begin
          w_shift_nxt = r_shift >> 1;
          w_bit_nxt   = r_bit + 1'b1;
          if (r_bit == BIT_W'(WIDTH - 1)) w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        w_baud_nxt = w_bit_end ? '0 : r_baud + 1'b1;
        if (w_bit_end) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Line level follows the next state, so tx/busy only move on bit boundaries
  always_comb begin
    o_fifo_pop = w_pop;
    w_busy_nxt = (w_state_nxt != S_IDLE);
    case (w_state_nxt)
      S_START: w_tx_nxt = 1'b0;
      S_DATA:  w_tx_nxt = w_shift_nxt[0];
      default: w_tx_nxt = 1'b1;
    endcase
  end

  assign o_tx   = r_tx;
  assign o_busy = r_busy;
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a queue-backed FIFO model and per-cycle pop legality check.
module tb_fifo_uart_tx;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst, enable, fifo_empty, fifo_pop, tx, busy;
  logic [7:0] fifo_data;

  logic       rst_d, en_d, p_last, eq_m;
  logic [7:0] q[$];
  logic [7:0] tmp;
  int         total, bad, cyc, t0;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .WIDTH(8)) dut (
    .clk(clk), .rst(rst), .i_enable(enable), .i_fifo_empty(fifo_empty),
    .i_fifo_data(fifo_data), .o_fifo_pop(fifo_pop), .o_tx(tx), .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic got, input logic exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, got, exp);
    end
  endtask

  task automatic chkn(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  // One clock: apply pending inputs just after the edge, settle, then check pop legality.
  task automatic cycle();
    @(posedge clk);
    #1;
    eq_m = rst ? 1'b1 : fifo_empty;
    if (p_last && q.size() > 0) tmp = q.pop_front();
    rst        = rst_d;
    enable     = en_d;
    fifo_empty = (q.size() == 0);
    fifo_data  = (q.size() > 0) ? q[0] : 8'h00;
    #4;
    p_last = fifo_pop;
    cyc++;
    chk1("pop_legal", fifo_pop && (rst || fifo_empty || eq_m), 1'b0);
  endtask

  task automatic idle_chk(input string tag);
    chk1({tag, "_tx"}, tx, 1'b1);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_pop"}, fifo_pop, 1'b0);
  endtask

  // Checks n cycles of the frame for byte b, starting the cycle after its pop.
  task automatic frame(input logic [7:0] b, input int en_off, input int n);
    logic       e;
    logic [2:0] idx;
    for (int i = 0; i < n; i++) begin
      if (i == en_off) en_d = 1'b0;
      cycle();
      idx = 3'((i - CPB) / CPB);
      if (i < CPB) e = 1'b0;
      else if (i >= 9 * CPB) e = 1'b1;
      else e = b[idx];
      chk1("frame_tx", tx, e);
      chk1("frame_busy", busy, 1'b1);
      chk1("frame_pop", fifo_pop, 1'b0);
    end
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; p_last = 1'b0; eq_m = 1'b1;
    q.push_back(8'h11);
    rst = 1'b1; rst_d = 1'b1; enable = 1'b1; en_d = 1'b1;
    fifo_empty = 1'b0; fifo_data = 8'h11;

    // reset with a non-empty FIFO
    for (int i = 0; i < 3; i++) begin
      cycle();
      idle_chk("reset");
    end
    rst_d = 1'b0;
    cycle();
    idle_chk("post_reset");
    cycle();
    chk1("first_pop", fifo_pop, 1'b1);
    frame(8'h11, -1, 10 * CPB);
    cycle();
    idle_chk("after_11");

    // single byte 0xA5 after the FIFO was empty
    cycle();
    q.push_back(8'hA5);
    cycle();
    chk1("a5_empty_q_block", fifo_pop, 1'b0);
    cycle();
    chk1("a5_pop", fifo_pop, 1'b1);
    chk1("a5_pop_data", fifo_data === 8'hA5, 1'b1);
    frame(8'hA5, -1, 10 * CPB);
    cycle();
    idle_chk("after_a5");

    // back-to-back 0x00, 0xFF
    q.push_back(8'h00);
    q.push_back(8'hFF);
    cycle();
    chk1("b2b_empty_q_block", fifo_pop, 1'b0);
    cycle();
    chk1("b2b_pop0", fifo_pop, 1'b1);
    t0 = cyc;
    frame(8'h00, -1, 10 * CPB);
    cycle();
    chk1("b2b_pop1", fifo_pop, 1'b1);
    chk1("b2b_gap_busy", busy, 1'b0);
    chk1("b2b_gap_tx", tx, 1'b1);
    chkn("b2b_spacing", cyc - t0, 10 * CPB + 1);
    frame(8'hFF, -1, 10 * CPB);
    cycle();
    idle_chk("after_ff");

    // enable dropped mid-frame: frame finishes, no further pop until enable returns
    q.push_back(8'h3C);
    q.push_back(8'h5A);
    cycle();
    cycle();
    chk1("en_pop0", fifo_pop, 1'b1);
    frame(8'h3C, 5 * CPB, 10 * CPB);
    for (int i = 0; i < 5; i++) begin
      cycle();
      idle_chk("en_off_idle");
    end
    en_d = 1'b1;
    cycle();
    chk1("en_on_pop", fifo_pop, 1'b1);
    frame(8'h5A, -1, 10 * CPB);
    cycle();
    idle_chk("after_5a");

    // reset in the middle of DATA bit 3: byte is dropped, next byte follows
    q.push_back(8'hC3);
    q.push_back(8'h96);
    cycle();
    cycle();
    chk1("abort_pop", fifo_pop, 1'b1);
    frame(8'hC3, -1, 4 * CPB + 2);
    rst_d = 1'b1;
    cycle();
    chk1("abort_rst_pop", fifo_pop, 1'b0);
    rst_d = 1'b0;
    cycle();
    idle_chk("abort_after_rst");
    cycle();
    chk1("abort_next_pop", fifo_pop, 1'b1);
    chk1("abort_next_data", fifo_data === 8'h96, 1'b1);
    frame(8'h96, -1, 10 * CPB);

    // FIFO drained: line stays idle with no pops
    for (int i = 0; i < 6; i++) begin
      cycle();
      idle_chk("empty_idle");
    end
    chkn("queue_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
